// File: rtl/drawing_cmd_issuer.sv
// Queues 3-bit drawing-unit commands and issues them one at a time over a
// four-phase req/ack handshake to the drawing demux.
module drawing_cmd_issuer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          cmd_valid,
  input  logic [2:0]                    cmd_code,
  output logic                          cmd_ready,
  output logic                          de_req,
  output logic [2:0]                    de_cmd,
  input  logic                          de_ack,
  output logic                          busy,
  output logic                          done,
  output logic                          proto_err,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: a command is pushed on a rising edge where cmd_valid && cmd_ready.
  // Downstream: de_req rises with de_cmd valid, falls once de_ack is seen high,
  // and the next command waits until de_ack has been seen low again.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic          de_req_nxt, done_nxt;
  logic [2:0]    de_cmd_nxt;
  logic          ack_q;

  assign cmd_ready = (count < (AW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0) && !de_ack;
  assign busy      = (count != '0) || (state != IDLE);
  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_code;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      de_req    <= 1'b0;
      de_cmd    <= 3'd0;
      done      <= 1'b0;
      proto_err <= 1'b0;
      // Starts high so an ack still asserted across reset is not read as a rise.
      ack_q     <= 1'b1;
    end else begin
      state  <= state_nxt;
      de_req <= de_req_nxt;
      de_cmd <= de_cmd_nxt;
      done   <= done_nxt;
      ack_q  <= de_ack;
      if ((state == IDLE) && de_ack && !ack_q) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    de_req_nxt = de_req;
    de_cmd_nxt = de_cmd;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt  = REQ;
          de_req_nxt = 1'b1;
          de_cmd_nxt = mem[rd_ptr];
        end
      end
      REQ: begin
        if (de_ack) begin
          state_nxt  = REL;
          de_req_nxt = 1'b0;
        end
      end
      REL: begin
        if (!de_ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        de_req_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_drawing_cmd_issuer.sv
// Bench for drawing_cmd_issuer: scoreboarded pushes, an automatic responder,
// table-driven single handshakes and hand-written corner sequences.
module tb_drawing_cmd_issuer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_ready;
  logic       de_req;
  logic [2:0] de_cmd;
  logic       de_ack;
  logic       busy;
  logic       done;
  logic       proto_err;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  logic        man_ack;
  logic        resp_en;
  logic        resp_ack;
  int unsigned ack_dly;
  int unsigned dly_cnt;

  logic [2:0] exp_q[$];
  logic [2:0] last_cmd;
  logic       prev_req;
  logic       prev_done;
  int         done_cnt;
  int         n_cmp;
  int         n_err;

  typedef struct {
    logic [2:0]  code;
    int unsigned dly;
    logic [2:0]  exp_cmd;
  } vec_t;
  vec_t vecs[6];

  assign de_ack = resp_en ? resp_ack : man_ack;

  drawing_cmd_issuer #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .de_req    (de_req),
    .de_cmd    (de_cmd),
    .de_ack    (de_ack),
    .busy      (busy),
    .done      (done),
    .proto_err (proto_err),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // responder: ack after ack_dly+1 cycles of req, drop one cycle after req falls
  always @(negedge clk) begin
    if (!resp_en) begin
      resp_ack = 1'b0;
      dly_cnt  = 0;
    end else if (de_req && !resp_ack) begin
      if (dly_cnt >= ack_dly) begin
        resp_ack = 1'b1;
        dly_cnt  = 0;
      end else begin
        dly_cnt++;
      end
    end else if (!de_req && resp_ack) begin
      resp_ack = 1'b0;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (!n_reset) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (de_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(de_cmd), 32'hffff_ffff);
        end else begin
          check("issue_order", 32'(de_cmd), 32'(exp_q.pop_front()));
        end
        last_cmd = de_cmd;
      end else if (dbg_state != 2'd0 && de_cmd !== last_cmd) begin
        check("de_cmd_stable", 32'(de_cmd), 32'(last_cmd));
      end
      if (done) begin
        done_cnt++;
        check("done_cmd", 32'(de_cmd), 32'(last_cmd));
        if (prev_done) check("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_req  = de_req;
      prev_done = done;
    end
  end

  // driver tasks
  task automatic push_cmd(input logic [2:0] code, output bit accepted);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = code;
    accepted  = cmd_ready;
    if (accepted) exp_q.push_back(code);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_req(input string name, input int budget);
    int n = 0;
    while (!de_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!de_req) check({name, "_req_timeout"}, 32'(de_req), 32'd1);
  endtask

  initial begin
    bit acc;
    int d0;
    n_cmp = 0; n_err = 0; done_cnt = 0;
    n_reset = 1'b0; cmd_valid = 1'b0; cmd_code = 3'd0;
    man_ack = 1'b0; resp_en = 1'b0; ack_dly = 1;
    last_cmd = 3'd0; prev_req = 1'b0; prev_done = 1'b0;

    vecs[0] = '{code: 3'd5, dly: 1, exp_cmd: 3'd5};
    vecs[1] = '{code: 3'd0, dly: 0, exp_cmd: 3'd0};
    vecs[2] = '{code: 3'd7, dly: 3, exp_cmd: 3'd7};
    vecs[3] = '{code: 3'd2, dly: 0, exp_cmd: 3'd2};
    vecs[4] = '{code: 3'd6, dly: 5, exp_cmd: 3'd6};
    vecs[5] = '{code: 3'd1, dly: 2, exp_cmd: 3'd1};

    #12;
    check("rst_de_req", 32'(de_req), 32'd0);
    check("rst_de_cmd", 32'(de_cmd), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    n_reset = 1'b1;
    resp_en = 1'b1;

    // single handshakes from the vector table
    for (int i = 0; i < 6; i++) begin
      ack_dly = vecs[i].dly;
      d0 = done_cnt;
      push_cmd(vecs[i].code, acc);
      check("vec_accept", 32'(acc), 32'd1);
      wait_idle("vec", 40);
      check("vec_de_cmd", 32'(de_cmd), 32'(vecs[i].exp_cmd));
      check("vec_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("vec_busy_after", 32'(busy), 32'd0);
      check("vec_de_req_after", 32'(de_req), 32'd0);
    end
    check("no_proto_err", 32'(proto_err), 32'd0);

    // random burst, pushing whenever there is room
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      int tries = 0;
      ack_dly = $urandom_range(0, 3);
      do begin
        push_cmd(3'($urandom_range(0, 7)), acc);
        tries++;
      end while (!acc && tries < 30);
      if (!acc) check("burst_accept", 32'(acc), 32'd1);
    end
    wait_idle("burst", 200);
    check("burst_done_cnt", 32'(done_cnt - d0), 32'd10);
    check("burst_q_empty", 32'(exp_q.size()), 32'd0);

    // stray ack pulse while idle and empty
    resp_en = 1'b0;
    @(negedge clk); man_ack = 1'b1;
    @(negedge clk); man_ack = 1'b0;
    @(negedge clk);
    check("proto_err_set", 32'(proto_err), 32'd1);
    repeat (3) @(negedge clk);
    check("proto_err_sticky", 32'(proto_err), 32'd1);
    resp_en = 1'b1; ack_dly = 1;
    d0 = done_cnt;
    push_cmd(3'd3, acc);
    wait_idle("after_err", 40);
    check("after_err_done", 32'(done_cnt - d0), 32'd1);
    check("proto_err_still", 32'(proto_err), 32'd1);

    // fill the FIFO with ack held high, then try a fifth push
    resp_en = 1'b0;
    @(negedge clk); man_ack = 1'b1;
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) begin
      push_cmd(3'(i), acc);
      check("fill_accept", 32'(acc), 32'd1);
    end
    check("full_ready_low", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(dbg_count), 32'd4);
    push_cmd(3'd6, acc);
    check("full_reject", 32'(acc), 32'd0);
    check("full_count_kept", 32'(dbg_count), 32'd4);
    @(negedge clk); man_ack = 1'b0;
    check("pop_cycle_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_pop", 32'(cmd_ready), 32'd1);
    resp_en = 1'b1;
    wait_idle("fill", 100);
    check("fill_done_cnt", 32'(done_cnt - d0), 32'd4);
    check("fill_q_empty", 32'(exp_q.size()), 32'd0);

    // simultaneous push and pop at occupancy 2
    resp_en = 1'b0;
    @(negedge clk); man_ack = 1'b1;
    push_cmd(3'd5, acc);
    push_cmd(3'd2, acc);
    check("pp_count_before", 32'(dbg_count), 32'd2);
    man_ack = 1'b0;
    push_cmd(3'd6, acc);
    check("pp_accept", 32'(acc), 32'd1);
    check("pp_count_after", 32'(dbg_count), 32'd2);
    check("pp_req", 32'(de_req), 32'd1);
    resp_en = 1'b1;
    wait_idle("pp", 100);
    check("pp_q_empty", 32'(exp_q.size()), 32'd0);

    // reset in REQ with ack held, then wait out the leftover ack
    resp_en = 1'b0;
    push_cmd(3'd3, acc);
    wait_req("rst_mid", 20);
    man_ack = 1'b1;
    #2 n_reset = 1'b0;
    #1;
    exp_q.delete();
    check("rstmid_de_req", 32'(de_req), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_count", 32'(dbg_count), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'd0);
    @(negedge clk); n_reset = 1'b1;
    d0 = done_cnt;
    push_cmd(3'd7, acc);
    repeat (5) @(negedge clk);
    check("held_ack_no_req", 32'(de_req), 32'd0);
    check("held_ack_count", 32'(dbg_count), 32'd1);
    man_ack = 1'b0;
    @(negedge clk);
    wait_req("after_rst", 20);
    check("after_rst_cmd", 32'(de_cmd), 32'd7);
    resp_en = 1'b1;
    wait_idle("after_rst", 40);
    check("after_rst_done", 32'(done_cnt - d0), 32'd1);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/drawing_cmd_issuer.md
DRAWING_CMD_ISSUER -- requirements
Module: drawing_cmd_issuer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of queued commands (power of two, 2..16).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  host offers a command this cycle.
REQ-005 cmd_code  input  3  drawing unit select (0..7) for the offered command.
REQ-006 cmd_ready  output  1  FIFO can accept; push occurs when cmd_valid && cmd_ready at clk edge.
REQ-007 de_req  output  1  four-phase request to drawing demux, registered.
REQ-008 de_cmd  output  3  unit select accompanying de_req, registered.
REQ-009 de_ack  input  1  four-phase acknowledge (OR of unit acks), synchronous to clk.
REQ-010 busy  output  1  high when FIFO non-empty or FSM not in IDLE.
REQ-011 done  output  1  one-cycle pulse per completed handshake.
REQ-012 proto_err  output  1  sticky flag, de_ack rose while de_req low.

Function
REQ-013 FIFO SHALL be FIFO_DEPTH entries of 3 bits, strict first-in first-out order.
REQ-014 cmd_ready SHALL equal (occupancy < FIFO_DEPTH); a pop in the same cycle does not raise it.
REQ-015 Push to an empty FIFO SHALL not bypass; entry is poppable from the following cycle.
REQ-016 Simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 FSM states: IDLE, REQ, REL; encoding free.
REQ-018 IDLE -> REQ when FIFO non-empty and de_ack==0; pop head into de_cmd, set de_req=1 on the same edge.
REQ-019 IDLE SHALL stay put while de_ack==1 (waits out an ack left over from before reset).
REQ-020 REQ -> REL on first edge sampling de_ack==1; de_req=0 on that edge, de_cmd held.
REQ-021 REL -> IDLE on first edge sampling de_ack==0; done=1 for exactly that following cycle.
REQ-022 de_cmd SHALL remain stable from de_req rise until the FSM leaves REL.
REQ-023 Minimum handshake: req high 1 cycle after ack seen; back-to-back commands separated by at least one IDLE cycle with de_req low.
REQ-024 No timeout; REQ and REL wait indefinitely.
REQ-025 proto_err SHALL set when de_ack sampled 1 in IDLE while it was 0 the previous cycle; it clears only on reset.
REQ-026 busy SHALL be combinational from occupancy and state.

Reset
REQ-027 n_reset low SHALL immediately force de_req=0, de_cmd=0, done=0, proto_err=0, busy=0, state IDLE, FIFO empty (cmd_ready=1).
REQ-028 Reset mid-handshake SHALL discard in-flight and queued commands; no retry.
REQ-029 After reset release, first request SHALL wait for de_ack==0 per REQ-019.

Verification
REQ-030 Push code 5, responder acks 2 cycles after req, drops 1 cycle after req falls -> de_cmd=5, de_req high until ack seen, one done pulse, busy low after.
REQ-031 Push 4 codes 1,2,3,4 back-to-back with ack held off -> cmd_ready low after 4th push (pop of 1 frees a slot next cycle), handshakes issue 1,2,3,4 in order, 4 done pulses.
REQ-032 Push 5th command while full -> not accepted; sequence contains only first four codes.
REQ-033 Assert n_reset during REQ with de_ack=1 held -> de_req=0 immediately, FIFO empty; after release push 7 -> no req until de_ack=0, then de_cmd=7.
REQ-034 Pulse de_ack while IDLE and FIFO empty -> proto_err=1 and stays 1; subsequent handshakes still complete normally.
REQ-035 Push and pop in same cycle with occupancy 2 -> occupancy stays 2, order preserved across pointer wrap.
